mdu_iter: RTL
=============

# mdu_iter

Parametrised iterative multiply/divide unit for the execute stage, sitting beside the combinational ALU. It computes signed and unsigned WIDTH×WIDTH products and quotient/remainder pairs over WIDTH cycles, holding results in architectural HI/LO registers. A start/busy/done handshake lets the hazard unit stall HI/LO consumers, and a flush aborts an in-flight operation.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
- srcA  in  WIDTH  multiplicand/dividend, or MTHI/MTLO data.
- srcB  in  WIDTH  multiplier/divisor.
- flush  in  1  abort the current operation (pipeline flush).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start with a MULT/MULTU/DIV/DIVU op latches the absolute values (signed ops) or raw operands (unsigned ops), the op, and the result signs; clears the counter; moves to RUN.
  - start with MTHI/MTLO writes srcA into hi or lo at that edge and stays in IDLE. done pulses the next cycle.
- RUN: one radix-2 step per cycle, WIDTH cycles in total.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract. Partial remainder is WIDTH+1 bits so no carry is lost.
- FIX:
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo and return to IDLE.
- Results:
  - Multiply: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2·WIDTH product.
  - Divide: lo = quotient truncated toward zero, hi = remainder.
- Divide by zero (DIV or DIVU): hi = srcA, lo = all ones. The full WIDTH-cycle latency still applies.
- Signed overflow (most-negative ÷ −1): lo = most-negative, hi = 0. This falls out of the magnitude datapath and needs no special case.
- start while busy is ignored. The hazard unit must not issue it.
- flush:
  - Any state returns to IDLE on the next edge.
  - hi/lo are not modified and no done pulse is generated.
  - flush and start in the same cycle: flush wins and start is dropped.
- Reset: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, counter = 0, operand registers = 0. Reset mid-operation discards the operation.

## Timing
- Mul/div: start sampled at edge E0.
  - busy is high from E0 through E0+WIDTH+1.
  - hi/lo update and done pulses at E0+WIDTH+1.
  - busy drops with done, i.e. busy and done are both high for that one cycle, then busy falls.
  - Latency is WIDTH+1 cycles.
- MTHI/MTLO: hi/lo update at E0; done pulses at E0+1; busy stays low.
- A new start is accepted in the cycle after done (back-to-back throughput WIDTH+2).
- Outputs busy, done, hi, lo are registered, with no combinational path from inputs.

## Structure
- Shared package mdu_pkg holds:
  - the op encodings: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5;
  - the state enum (IDLE/RUN/FIX).
- Sub-module mdu_step: purely combinational single radix-2 step (mode, accumulator/remainder, operand → next accumulator/remainder, quotient bit). It is instantiated once inside mdu_iter, with the FSM, counter and sign-fix logic in the parent.

## Test plan
All scenarios use WIDTH=32.
- MULT srcA=0xFFFFFFFF, srcB=0x00000002 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, one done pulse. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV srcA=0xFFFFFFF9 (−7), srcB=0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU srcA=7, srcB=0 → hi=0x00000007, lo=0xFFFFFFFF, still 33-cycle latency.
- DIV srcA=0x80000000, srcB=0xFFFFFFFF → lo=0x80000000, hi=0x00000000.
- Start MULT with hi/lo = 0x11111111/0x22222222, assert flush 10 cycles later → busy low next cycle, no done, hi/lo unchanged. A start issued the following cycle is accepted.
- Start DIVU, re-pulse start with different operands at cycle 5 → ignored, result matches the first operands. MTLO srcA=0xDEADBEEF in IDLE → lo=0xDEADBEEF at the next edge, done the cycle after, busy never high.
- Assert rst_n=0 mid-RUN → hi=lo=0, busy=done=0 immediately (asynchronous); after release a fresh MULTU 3×5 gives lo=15, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and the sequencing state enum.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational radix-2 step: shift-add for multiply, restoring
// shift-subtract for divide.
// Ports: div_i mode select; acc_i/acc_o 2*WIDTH accumulator (multiply
// product, or dividend/quotient in the low half); rem_i/rem_o partial
// remainder; opb_i multiplicand or divisor; qbit_o new quotient bit.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0]   rem_o,
    output logic               qbit_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;

    always_comb begin
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + (acc_i[0] ? {1'b0, opb_i} : '0);
        // Remainder widened by one bit so the shifted-in dividend bit
        // never drops a carry before the compare.
        shifted = {rem_i, acc_i[WIDTH-1]};
        qbit_o  = div_i & (shifted >= {1'b0, opb_i});
        if (div_i) begin
            // Quotient bit slot left at zero; parent merges qbit_o.
            acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b0};
            rem_o = qbit_o ? WIDTH'(shifted - {1'b0, opb_i})
                           : shifted[WIDTH-1:0];
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
            rem_o = rem_i;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply/divide unit with HI/LO registers.
// Ports: clk, rst_n (async active-low); start/op/srcA/srcB request;
// flush aborts; busy/done handshake; hi/lo architectural results.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 div_q, div_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 mt_q, mt_d;

    logic [2*WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]     step_rem;
    logic                 step_q;
    logic                 sgn_op, sa, sb;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [2*WIDTH-1:0]   prod;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .rem_i  (rem_q),
        .opb_i  (opb_q),
        .acc_o  (step_acc),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    always_comb begin
        sgn_op = (op == MDU_MULT) || (op == MDU_DIV);
        sa     = sgn_op & srcA[WIDTH-1];
        sb     = sgn_op & srcB[WIDTH-1];
        a_abs  = sa ? -srcA : srcA;
        b_abs  = sb ? -srcB : srcB;
        prod   = neg_lo_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        mt_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!flush) begin
                    // MTHI/MTLO report completion one cycle after the write.
                    done_d = mt_q;
                    if (start) begin
                        unique case (op)
                            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                                state_d  = RUN;
                                busy_d   = 1'b1;
                                cnt_d    = '0;
                                div_d    = (op == MDU_DIV) || (op == MDU_DIVU);
                                opb_d    = b_abs;
                                acc_d    = {{WIDTH{1'b0}}, a_abs};
                                rem_d    = '0;
                                neg_hi_d = sa;
                                // A zero divisor leaves the all-ones
                                // quotient unsigned.
                                neg_lo_d = (sa ^ sb) &
                                           !(div_d && (srcB == '0));
                            end
                            MDU_MTHI: begin
                                hi_d = srcA;
                                mt_d = 1'b1;
                            end
                            MDU_MTLO: begin
                                lo_d = srcA;
                                mt_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                    acc_d  = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
                    rem_d  = step_rem;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    busy_d = 1'b1;
                    done_d = 1'b1;
                    if (div_q) begin
                        lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_hi_q ? -rem_q : rem_q;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mt_q     <= mt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
